// File: rtl/regfile_access_ctrl.sv
// Command-driven master for the register file write port and Read_Reg1 port.
// Handles write (with optional read-back verify), single read and full dump, one response beat per register.
module regfile_access_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int VERIFY_WRITE = 1
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [ADDR_W-1:0] o_rsp_addr,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_rsp_last,
    output logic              o_busy,
    output logic              o_rf_RegWrite,
    output logic [ADDR_W-1:0] o_rf_Write_Reg,
    output logic [DATA_W-1:0] o_rf_writeData,
    output logic [ADDR_W-1:0] o_rf_Read_Reg1,
    input  logic [DATA_W-1:0] i_rf_Read_Data1
);

    typedef enum logic [2:0] {IDLE, WR, VFY, RD, RESP} state_t;

    localparam logic [1:0]        OP_WR    = 2'b00;
    localparam logic [1:0]        OP_RD    = 2'b01;
    localparam logic [1:0]        OP_DUMP  = 2'b10;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state, w_state;
    logic [1:0]          r_op, w_op;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [DATA_W-1:0]   r_data, w_data;
    logic [ADDR_W-1:0]   r_idx, w_idx;

    logic                r_cmd_ready, r_busy;
    logic                r_rsp_valid, w_rsp_valid;
    logic [ADDR_W-1:0]   r_rsp_addr, w_rsp_addr;
    logic [DATA_W-1:0]   r_rsp_data, w_rsp_data;
    logic                r_rsp_err, w_rsp_err;
    logic                r_rsp_last, w_rsp_last;
    logic                r_we, w_we;
    logic [ADDR_W-1:0]   r_wr_reg, w_wr_reg;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data;
    logic [ADDR_W-1:0]   r_rd_reg, w_rd_reg;
    logic [DATA_W-1:0]   w_expect;

    assign w_expect = (r_addr == '0) ? '0 : r_data;

    // Every output is a register, so the comb block computes the values the
    // outputs must carry in the state being entered, not the current one.
    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_addr      = r_addr;
        w_data      = r_data;
        w_idx       = r_idx;
        w_we        = 1'b0;
        w_wr_reg    = '0;
        w_wr_data   = '0;
        w_rd_reg    = '0;
        w_rsp_valid = 1'b0;
        w_rsp_addr  = r_rsp_addr;
        w_rsp_data  = r_rsp_data;
        w_rsp_err   = r_rsp_err;
        w_rsp_last  = r_rsp_last;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_op   = i_cmd_op;
                    w_addr = i_cmd_addr;
                    w_data = i_cmd_data;
                    case (i_cmd_op)
                        OP_WR: begin
                            w_state   = WR;
                            w_we      = (i_cmd_addr != '0);
                            w_wr_reg  = i_cmd_addr;
                            w_wr_data = i_cmd_data;
                        end
                        OP_RD: begin
                            w_state  = RD;
                            w_rd_reg = i_cmd_addr;
                        end
                        OP_DUMP: begin
                            w_state  = RD;
                            w_idx    = '0;
                            w_rd_reg = '0;
                        end
                        default: begin
                            w_state     = RESP;
                            w_rsp_valid = 1'b1;
                            w_rsp_addr  = i_cmd_addr;
                            w_rsp_data  = '0;
                            w_rsp_err   = 1'b1;
                            w_rsp_last  = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                if (VERIFY_WRITE != 0) begin
                    w_state  = VFY;
                    w_rd_reg = r_addr;
                end else begin
                    w_state     = RESP;
                    w_rsp_valid = 1'b1;
                    w_rsp_addr  = r_addr;
                    w_rsp_data  = r_data;
                    w_rsp_err   = 1'b0;
                    w_rsp_last  = 1'b1;
                end
            end
            VFY: begin
                w_state     = RESP;
                w_rsp_valid = 1'b1;
                w_rsp_addr  = r_addr;
                w_rsp_data  = i_rf_Read_Data1;
                w_rsp_err   = (i_rf_Read_Data1 != w_expect);
                w_rsp_last  = 1'b1;
            end
            RD: begin
                w_state     = RESP;
                w_rsp_valid = 1'b1;
                w_rsp_addr  = r_rd_reg;
                w_rsp_data  = i_rf_Read_Data1;
                w_rsp_err   = 1'b0;
                w_rsp_last  = (r_op == OP_DUMP) ? (r_idx == LAST_IDX) : 1'b1;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    if (r_op == OP_DUMP && !r_rsp_last) begin
                        w_state  = RD;
                        w_idx    = r_idx + ADDR_W'(1);
                        w_rd_reg = r_idx + ADDR_W'(1);
                    end else begin
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_idx       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_we        <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_rd_reg    <= '0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_idx       <= w_idx;
            r_cmd_ready <= (w_state == IDLE);
            r_busy      <= (w_state != IDLE);
            r_rsp_valid <= w_rsp_valid;
            r_rsp_addr  <= w_rsp_addr;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_rsp_last  <= w_rsp_last;
            r_we        <= w_we;
            r_wr_reg    <= w_wr_reg;
            r_wr_data   <= w_wr_data;
            r_rd_reg    <= w_rd_reg;
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_busy         = r_busy;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_addr     = r_rsp_addr;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_err      = r_rsp_err;
    assign o_rsp_last     = r_rsp_last;
    assign o_rf_RegWrite  = r_we;
    assign o_rf_Write_Reg = r_wr_reg;
    assign o_rf_writeData = r_wr_data;
    assign o_rf_Read_Reg1 = r_rd_reg;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file attached.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_last;
    logic        busy;
    logic        rf_we;
    logic [4:0]  rf_wr_reg;
    logic [31:0] rf_wr_data;
    logic [4:0]  rf_rd_reg;
    logic [31:0] rf_rd_data;

    regfile_access_ctrl #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .VERIFY_WRITE(1)) dut (
        .i_clock(clk), .i_rst(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_addr(rsp_addr),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_rsp_last(rsp_last),
        .o_busy(busy), .o_rf_RegWrite(rf_we), .o_rf_Write_Reg(rf_wr_reg),
        .o_rf_writeData(rf_wr_data), .o_rf_Read_Reg1(rf_rd_reg),
        .i_rf_Read_Data1(rf_rd_data)
    );

    always #5 clk = ~clk;

    // Register file: x0 reads as zero, contents survive controller reset.
    logic [31:0] rf [0:31];
    logic        rf_clr = 1'b1;
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (rf_we && rf_wr_reg != 5'd0) begin
            rf[rf_wr_reg] <= rf_wr_data;
        end
    end
    assign rf_rd_data = (rf_rd_reg == 5'd0) ? 32'd0 : rf[rf_rd_reg];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
        logic        last;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int we_cnt = 0;
    int rdy_in_dump = 0;
    bit in_dump = 1'b0;
    bit rdy_mode = 1'b0;
    logic [31:0] shadow [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // rsp_ready source: held high, or toggled every cycle for backpressure
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rsp_ready = rdy_mode ? ~rsp_ready : 1'b1;
        end
    end

    // Monitor: latency, stall stability, strobe counting and scoreboard pop
    bit          pv = 1'b0;
    bit          pstall = 1'b0;
    logic [38:0] held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && !pv && sbq.size() > 0 && sbq[0].lat >= 0)
                chk("latency", 64'(cyc - hs_cyc + 1), 64'(sbq[0].lat));
            if (pstall) begin
                chk("stall_valid_held", {63'd0, rsp_valid}, 64'd1);
                chk("stall_fields_stable", {25'd0, rsp_addr, rsp_data, rsp_err, rsp_last}, {25'd0, held});
            end
            if (rf_we) begin
                we_cnt++;
                chk("no_x0_write", {59'd0, rf_wr_reg == 5'd0}, 64'd0);
            end
            if (in_dump && cmd_ready) rdy_in_dump++;
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", {59'd0, rsp_addr}, 64'hFFFF);
                end else begin
                    chk("rsp_beat", {25'd0, rsp_addr, rsp_data, rsp_err, rsp_last},
                        {25'd0, sbq[0].addr, sbq[0].data, sbq[0].err, sbq[0].last});
                    void'(sbq.pop_front());
                end
            end
            pstall = rsp_valid && !rsp_ready;
            held   = {rsp_addr, rsp_data, rsp_err, rsp_last};
            pv     = rsp_valid;
        end else begin
            pstall = 1'b0;
            pv     = 1'b0;
        end
    end

    task automatic expect_beat(input logic [4:0] a, input logic [31:0] d, input logic e,
                               input logic l, input int lat);
        exp_t x;
        x.addr = a; x.data = d; x.err = e; x.last = l; x.lat = lat;
        sbq.push_back(x);
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(posedge clk); #1;
        hs_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((sbq.size() != 0 || busy) && t < 600) begin @(negedge clk); t++; end
        chk(name, {62'd0, sbq.size() == 0, busy}, 64'h2);
    endtask

    task automatic expect_dump();
        for (int i = 0; i < 32; i++) expect_beat(5'(i), shadow[i], 1'b0, (i == 31), -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int t;
        for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rsp_valid, rsp_addr, rsp_data, rsp_err, rsp_last, busy, cmd_ready,
                              rf_we, rf_wr_reg, rf_wr_data, rf_rd_reg}, 118'd0);
        rf_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {62'd0, cmd_ready, busy}, 64'h2);

        // write x3 with verify
        w0 = we_cnt;
        expect_beat(5'd3, 32'hAABBCCDD, 1'b0, 1'b1, 3);
        send(2'b00, 5'd3, 32'hAABBCCDD);
        @(negedge clk);
        chk("wr_strobe_cycle1", {rf_we, rf_wr_reg, rf_wr_data}, {1'b1, 5'd3, 32'hAABBCCDD});
        wait_done("wr3_done");
        chk("wr3_we_count", 64'(we_cnt - w0), 64'd1);
        shadow[3] = 32'hAABBCCDD;

        // write x5 then read it back
        w0 = we_cnt;
        expect_beat(5'd5, 32'h11223344, 1'b0, 1'b1, 3);
        send(2'b00, 5'd5, 32'h11223344);
        wait_done("wr5_done");
        chk("wr5_we_count", 64'(we_cnt - w0), 64'd1);
        shadow[5] = 32'h11223344;
        w0 = we_cnt;
        expect_beat(5'd5, 32'h11223344, 1'b0, 1'b1, 2);
        send(2'b01, 5'd5, 32'h0);
        wait_done("rd5_done");
        chk("rd5_no_write", 64'(we_cnt - w0), 64'd0);

        // write x0 is suppressed and verifies against zero
        w0 = we_cnt;
        expect_beat(5'd0, 32'h0, 1'b0, 1'b1, 3);
        send(2'b00, 5'd0, 32'hFFFFFFFF);
        wait_done("wr0_done");
        chk("wr0_no_write", 64'(we_cnt - w0), 64'd0);

        // dump with rsp_ready toggling
        w0 = we_cnt;
        expect_dump();
        rdy_mode = 1'b1;
        send(2'b10, 5'd17, 32'h0);
        in_dump = 1'b1;
        rdy_in_dump = 0;
        wait_done("dump_done");
        in_dump = 1'b0;
        rdy_mode = 1'b0;
        chk("dump_cmd_ready_low", 64'(rdy_in_dump), 64'd0);
        chk("dump_no_write", 64'(we_cnt - w0), 64'd0);

        // reserved opcode
        w0 = we_cnt;
        repeat (2) @(negedge clk);
        expect_beat(5'd7, 32'h0, 1'b1, 1'b1, 1);
        send(2'b11, 5'd7, 32'h12345678);
        wait_done("rsv_done");
        chk("rsv_no_write", 64'(we_cnt - w0), 64'd0);

        // reset in the middle of a dump
        expect_dump();
        send(2'b10, 5'd0, 32'h0);
        t = 0;
        while (!(rsp_valid && rsp_addr == 5'd10) && t < 200) begin @(negedge clk); t++; end
        chk("dump_beat10_seen", {58'd0, rsp_valid, rsp_addr}, {58'd0, 1'b1, 5'd10});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {60'd0, rsp_valid, busy, rf_we, cmd_ready}, 64'd0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", {62'd0, cmd_ready, busy}, 64'h2);
        expect_beat(5'd3, 32'hAABBCCDD, 1'b0, 1'b1, 2);
        send(2'b01, 5'd3, 32'h0);
        wait_done("rd3_after_reset");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Command-driven master for the single-cycle processor's RegisterFile write port and Read_Reg1 port.
- Used for debug, preload and dump of architectural registers, e.g. from a host bridge or a self-checking harness.
- Accepts write / read / dump commands over a valid/ready handshake.
- Sequences the register-file port accesses and returns one response beat per register over a valid/ready handshake.

Parameters:
- NUM_REGS, 32, number of registers walked by a dump.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- VERIFY_WRITE, 1, when 1 each write is read back and compared; when 0 no read-back.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 write, 01 read, 10 dump, 11 reserved.
- cmd_addr  in  ADDR_W  target register (ignored for dump).
- cmd_data  in  DATA_W  write data.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts beat.
- rsp_addr  out  ADDR_W  register the beat refers to.
- rsp_data  out  DATA_W  read or read-back data.
- rsp_err  out  1  verify mismatch or reserved op.
- rsp_last  out  1  final beat of a command.
- busy  out  1  high in any state other than IDLE.
- rf_RegWrite  out  1  to RegisterFile RegWrite.
- rf_Write_Reg  out  ADDR_W  to Write_Reg.
- rf_writeData  out  DATA_W  to writeData.
- rf_Read_Reg1  out  ADDR_W  to Read_Reg1.
- rf_Read_Data1  in  DATA_W  from Read_Data1; combinational, valid in the same cycle Read_Reg1 is driven.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including cmd_ready, rf_RegWrite and rsp_valid.
  - The dump index and captured command are cleared.
- After rst deasserts, cmd_ready=1 in IDLE.
- All outputs are registered. Reset mid-operation aborts the command with no response, and rf_RegWrite drops immediately.
- States: IDLE, WR, VFY, RD, RESP.
- IDLE:
  - cmd_ready=1; no other state asserts it, and commands are not queued.
  - A handshake (cmd_valid & cmd_ready) latches op, addr and data.
  - Next state: write -> WR; read -> RD; dump -> RD with index=0; reserved -> RESP with rsp_err=1, rsp_data=0, rsp_addr=cmd_addr, rsp_last=1.
- WR (exactly one cycle):
  - rf_Write_Reg=addr, rf_writeData=data.
  - rf_RegWrite=1, except rf_RegWrite stays 0 when addr=0 (x0 is never written).
  - Next state: VFY if VERIFY_WRITE=1, else RESP with rsp_data=data, rsp_err=0.
- VFY (one cycle):
  - rf_Read_Reg1=addr; rf_Read_Data1 is captured into rsp_data at the cycle end.
  - rsp_err = (captured != expected); expected is data, or 0 when addr=0.
  - Next state: RESP.
- RD (one cycle):
  - rf_Read_Reg1 = addr, or the dump index for a dump; rf_Read_Data1 is captured into rsp_data.
  - rsp_addr is the register read; rsp_err=0.
  - Next state: RESP.
- RESP:
  - rsp_valid=1. rsp_addr, rsp_data, rsp_err and rsp_last are held stable until rsp_ready.
  - On handshake for a non-dump command or the final dump beat, go to IDLE.
  - On handshake for a non-final dump beat, increment the index and go to RD.
- Dump: rsp_last=1 only on index=NUM_REGS-1; the index never wraps.
- rf_RegWrite is high only in WR: one cycle per write command, never during read or dump.
- Latency (cmd handshake at cycle 0):
  - write with verify: rsp_valid from cycle 3.
  - write without verify: rsp_valid from cycle 2.
  - read: rsp_valid from cycle 2.
  - dump beat k: earliest cycle 2+2k with no backpressure.
  - reserved op: rsp_valid from cycle 1.
- Backpressure: rsp_ready low stalls in RESP indefinitely; no beats are dropped or duplicated.

Test Plan:
- Reset, then write addr=3, data=AABBCCDD -> rf_RegWrite high exactly 1 cycle (cycle 1), rsp_valid at cycle 3, rsp_addr=3, rsp_data=AABBCCDD, rsp_err=0, rsp_last=1.
- Write addr=5, data=11223344, then read addr=5 -> read response rsp_data=11223344, rsp_err=0, and rf_RegWrite stays 0 throughout the read.
- Write addr=0, data=FFFFFFFF -> rf_RegWrite stays 0, rsp_data=0, rsp_err=0.
- Dump after writes to regs 3 and 5, with rsp_ready toggled 1/0 every cycle:
  - exactly 32 beats, addr 0..31 in order;
  - beat 3 = AABBCCDD, beat 5 = 11223344;
  - rsp_last only on addr 31; outputs stable while stalled;
  - cmd_ready=0 for the whole dump.
- cmd_op=11, addr=7 -> rsp_valid at cycle 1, rsp_err=1, rsp_data=0, rsp_addr=7, no register-file access.
- Assert rst low during dump beat 10 -> rsp_valid, busy and rf_RegWrite go to 0 immediately. After release, cmd_ready=1 and a read of addr=3 returns AABBCCDD.
